// File: rtl/wb_burst_pkg.sv
// rtl/wb_burst_pkg.sv - Wishbone burst cycle types, burst extensions, FSM states and address stepping
package wb_burst_pkg;

  localparam logic [2:0] CTI_CLASSIC = 3'b000;
  localparam logic [2:0] CTI_CONST   = 3'b001;
  localparam logic [2:0] CTI_INC     = 3'b010;
  localparam logic [2:0] CTI_EOB     = 3'b111;

  localparam logic [1:0] BTE_LINEAR  = 2'b00;
  localparam logic [1:0] BTE_WRAP4   = 2'b01;
  localparam logic [1:0] BTE_WRAP8   = 2'b10;
  localparam logic [1:0] BTE_WRAP16  = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_BURST
  } state_t;

  // Wrap bursts step only the low word-address bits; everything above holds.
  function automatic logic [31:0] next_adr(input logic [31:0] adr, input logic [1:0] bte);
    logic [31:0] n;
    n = adr;
    case (bte)
      BTE_LINEAR: n      = adr + 32'd4;
      BTE_WRAP4:  n[3:2] = adr[3:2] + 2'd1;
      BTE_WRAP8:  n[4:2] = adr[4:2] + 3'd1;
      BTE_WRAP16: n[5:2] = adr[5:2] + 4'd1;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/wb_sp_ram.sv
// rtl/wb_sp_ram.sv - single-port byte-writable RAM, synchronous write-first read
module wb_sp_ram #(
  parameter int DW     = 32,
  parameter int DEPTH  = 1024,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [DW/8-1:0]   sel,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DW-1:0]     wdata,
  output logic [DW-1:0]     rdata
);

  logic [DW-1:0] mem [DEPTH];
  logic [DW-1:0] merged;

  always_comb begin
    merged = mem[addr];
    for (int b = 0; b < DW/8; b++) begin
      if (sel[b]) merged[8*b +: 8] = wdata[8*b +: 8];
    end
  end

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= merged;
    rdata <= we ? merged : mem[addr];
  end

endmodule

// File: rtl/wb_burst_mem_slave.sv
// rtl/wb_burst_mem_slave.sv - Wishbone B3 registered-feedback burst slave over scratch RAM
module wb_burst_mem_slave
  import wb_burst_pkg::*;
#(
  parameter int DW          = 32,
  parameter int AW          = 32,
  parameter int MEM_WORDS   = 1024,
  parameter int WAIT_STATES = 0
) (
  input  logic            wb_clk_i,
  input  logic            wb_rst_i,
  input  logic [AW-1:0]   wb_adr_i,
  input  logic [DW-1:0]   wb_dat_i,
  input  logic [DW/8-1:0] wb_sel_i,
  input  logic            wb_we_i,
  input  logic            wb_cyc_i,
  input  logic            wb_stb_i,
  input  logic [2:0]      wb_cti_i,
  input  logic [1:0]      wb_bte_i,
  output logic [DW-1:0]   wb_dat_o,
  output logic            wb_ack_o,
  output logic            wb_err_o,
  output logic            wb_rty_o
);

  localparam int IDX_W = $clog2(MEM_WORDS);

  state_t           state, state_d;
  logic [AW-1:0]    adr_q, adr_d;
  logic [3:0]       wait_cnt, wait_cnt_d;
  logic             ack_q, active, out_of_range, ram_we;
  logic [IDX_W-1:0] ram_addr;
  logic [DW-1:0]    ram_rdata;

  assign ack_q        = (state == ST_BURST);
  assign active       = ack_q & wb_cyc_i & wb_stb_i;
  assign out_of_range = (adr_q[AW-1:IDX_W+2] != '0);
  assign wb_ack_o     = active & ~out_of_range;
  assign wb_err_o     = active & out_of_range;
  assign wb_rty_o     = 1'b0;
  assign wb_dat_o     = ack_q ? ram_rdata : '0;

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state    <= ST_IDLE;
      adr_q    <= '0;
      wait_cnt <= '0;
    end else begin
      state    <= state_d;
      adr_q    <= adr_d;
      wait_cnt <= wait_cnt_d;
    end
  end

  always_comb begin
    state_d    = state;
    adr_d      = adr_q;
    wait_cnt_d = wait_cnt;
    if (!wb_cyc_i) begin
      state_d = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: begin
          if (wb_stb_i) begin
            state_d    = ST_WAIT;
            adr_d      = wb_adr_i;
            wait_cnt_d = 4'(WAIT_STATES);
          end
        end
        ST_WAIT: begin
          if (wait_cnt == 4'd0) state_d = ST_BURST;
          else                  wait_cnt_d = wait_cnt - 4'd1;
        end
        ST_BURST: begin
          if (wb_err_o) begin
            state_d = ST_IDLE;
          end else if (wb_ack_o) begin
            case (wb_cti_i)
              CTI_INC:   adr_d = AW'(next_adr(32'(adr_q), wb_bte_i));
              CTI_CONST: adr_d = adr_q;
              default:   state_d = ST_IDLE;
            endcase
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Reads look one beat ahead so data for the next address is ready on the next ack.
  assign ram_we   = wb_ack_o & wb_we_i;
  assign ram_addr = ram_we ? adr_q[IDX_W+1:2] : adr_d[IDX_W+1:2];

  wb_sp_ram #(
    .DW    (DW),
    .DEPTH (MEM_WORDS)
  ) u_ram (
    .clk   (wb_clk_i),
    .we    (ram_we),
    .sel   (wb_sel_i),
    .addr  (ram_addr),
    .wdata (wb_dat_i),
    .rdata (ram_rdata)
  );

endmodule

// File: tb/tb_wb_burst_mem_slave.sv
// tb/tb_wb_burst_mem_slave.sv - scoreboard bench for wb_burst_mem_slave against a word-map memory model
module tb_wb_burst_mem_slave;
  import wb_burst_pkg::*;

  localparam int          MEMW = 4096;
  localparam logic [31:0] TOP  = 32'(MEMW * 4);

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] adr, dat_w, dat, dat0, dat1;
  logic [3:0]  sel;
  logic        we, cyc, stb, tgt;
  logic [2:0]  cti;
  logic [1:0]  bte;
  logic        ack, err, rty, ack0, ack1, err0, err1, rty0, rty1;
  int          cyc_cnt = 0;
  int          n_vec = 0;
  int          n_bad = 0;

  typedef struct packed {
    logic        err;
    logic        rd;
    logic [31:0] data;
    logic [31:0] adr;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        mon_e;
  logic [31:0] mdl [longint];

  always #5 clk = ~clk;
  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  wb_burst_mem_slave #(.DW(32), .AW(32), .MEM_WORDS(MEMW), .WAIT_STATES(0)) dut0 (
    .wb_clk_i(clk), .wb_rst_i(rst), .wb_adr_i(adr), .wb_dat_i(dat_w), .wb_sel_i(sel),
    .wb_we_i(we), .wb_cyc_i(cyc & ~tgt), .wb_stb_i(stb), .wb_cti_i(cti), .wb_bte_i(bte),
    .wb_dat_o(dat0), .wb_ack_o(ack0), .wb_err_o(err0), .wb_rty_o(rty0));

  wb_burst_mem_slave #(.DW(32), .AW(32), .MEM_WORDS(MEMW), .WAIT_STATES(3)) dut1 (
    .wb_clk_i(clk), .wb_rst_i(rst), .wb_adr_i(adr), .wb_dat_i(dat_w), .wb_sel_i(sel),
    .wb_we_i(we), .wb_cyc_i(cyc & tgt), .wb_stb_i(stb), .wb_cti_i(cti), .wb_bte_i(bte),
    .wb_dat_o(dat1), .wb_ack_o(ack1), .wb_err_o(err1), .wb_rty_o(rty1));

  assign ack = tgt ? ack1 : ack0;
  assign err = tgt ? err1 : err0;
  assign rty = tgt ? rty1 : rty0;
  assign dat = tgt ? dat1 : dat0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_vec++;
    if (act !== expv) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, expv);
    end
  endtask

  function automatic bit mdl_oor(input logic [31:0] a);
    return a >= TOP;
  endfunction

  function automatic longint mkey(input bit t, input logic [31:0] a);
    return longint'(t) * 64'h1_0000_0000 + longint'(a >> 2);
  endfunction

  function automatic logic [31:0] mdl_next(input logic [31:0] a, input logic [1:0] b);
    int unsigned span;
    case (b)
      2'b00:   return a + 32'd4;
      2'b01:   span = 16;
      2'b10:   span = 32;
      default: span = 64;
    endcase
    return a - (a % span) + ((a + 32'd4) % span);
  endfunction

  task automatic mdl_write(input bit t, input logic [31:0] a, input logic [3:0] s, input logic [31:0] d);
    logic [31:0] w;
    w = mdl.exists(mkey(t, a)) ? mdl[mkey(t, a)] : 32'h0;
    for (int b = 0; b < 4; b++) if (s[b]) w[8*b +: 8] = d[8*b +: 8];
    mdl[mkey(t, a)] = w;
  endtask

  function automatic logic [2:0] beat_cti(input logic [2:0] mode, input int i, input int n);
    if (mode == CTI_CLASSIC) return CTI_CLASSIC;
    return (i == n - 1) ? CTI_EOB : mode;
  endfunction

  task automatic drive_beat(input bit t, input bit w, input logic [31:0] a, input logic [2:0] c,
                            input logic [1:0] b, input logic [3:0] s, input logic [31:0] d);
    exp_t e;
    adr = a; we = w; cti = c; bte = b; sel = s; dat_w = d;
    e.err = mdl_oor(a); e.rd = !w; e.adr = a; e.data = 32'h0;
    if (!e.err) begin
      if (w) mdl_write(t, a, s, d);
      else   e.data = mdl.exists(mkey(t, a)) ? mdl[mkey(t, a)] : 32'h0;
    end
    exp_q.push_back(e);
  endtask

  always @(negedge clk) begin
    if (!rst && (ack || err)) begin
      if (exp_q.size() == 0) begin
        chk("spurious_resp", {30'd0, ack, err}, 32'd0);
      end else begin
        mon_e = exp_q.pop_front();
        chk($sformatf("resp_kind@%h", mon_e.adr), {30'd0, ack, err}, mon_e.err ? 32'd1 : 32'd2);
        if (mon_e.rd && !mon_e.err) chk($sformatf("rdata@%h", mon_e.adr), dat, mon_e.data);
        chk("rty", {31'd0, rty}, 32'd0);
      end
    end
  end

  task automatic run_burst(input bit t, input bit w, input logic [31:0] a0, input logic [2:0] mode,
                           input logic [1:0] b, input int n, input logic [3:0] s, input logic [31:0] wd,
                           input int stall_at, input int stall_len, input int abort_at);
    logic [31:0] a;
    int          t0, i, guard;
    bit          last;
    a = a0; i = 0; guard = 0;
    @(posedge clk); #1;
    tgt = t; cyc = 1'b1; stb = 1'b1;
    drive_beat(t, w, a, beat_cti(mode, 0, n), b, s, wd);
    t0 = cyc_cnt;
    forever begin
      @(negedge clk);
      if (ack || err) begin
        if (i == 0) chk("first_ack_lat", 32'(cyc_cnt - t0 - 1), t ? 32'd4 : 32'd1);
        last = mdl_oor(a) || (i == n - 1);
        guard = 0;
        @(posedge clk); #1;
        i++;
        if (last) break;
        if (mode == CTI_INC) a = mdl_next(a, b);
        if (i == stall_at) begin
          stb = 1'b0;
          repeat (stall_len) begin
            @(negedge clk);
            chk("stall_ack", {31'd0, ack | err}, 32'd0);
            @(posedge clk);
          end
          #1; stb = 1'b1;
        end
        drive_beat(t, w, a, beat_cti(mode, i, n), b, s, $urandom);
        if (i == abort_at) begin
          #2;
          chk("pre_rst_ack", {31'd0, ack}, 32'd1);
          rst = 1'b1;
          #1;
          chk("rst_ack", {31'd0, ack}, 32'd0);
          chk("rst_dat", dat, 32'd0);
          @(posedge clk); #1;
          rst = 1'b0; cyc = 1'b0; stb = 1'b0;
          exp_q.delete();
          return;
        end
      end else begin
        guard++;
        if (guard > 40) begin
          n_vec++; n_bad++;
          $display("FAIL ack_timeout@%h: got no response in 40 cycles, expected ack or err", a);
          cyc = 1'b0; stb = 1'b0;
          exp_q.delete();
          return;
        end
      end
    end
    // stb still held: a finished cycle must not be acked again
    @(negedge clk);
    chk("ack_after_last", {31'd0, ack | err}, 32'd0);
    cyc = 1'b0; stb = 1'b0;
  endtask

  task automatic wr1(input bit t, input logic [31:0] a, input logic [3:0] s, input logic [31:0] d);
    run_burst(t, 1'b1, a, CTI_CLASSIC, BTE_LINEAR, 1, s, d, -1, 0, -1);
  endtask

  task automatic rd1(input bit t, input logic [31:0] a);
    run_burst(t, 1'b0, a, CTI_CLASSIC, BTE_LINEAR, 1, 4'hF, 32'h0, -1, 0, -1);
  endtask

  initial begin
    adr = 0; dat_w = 0; sel = 0; we = 0; cyc = 0; stb = 0; tgt = 0; cti = 0; bte = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ack0", {31'd0, ack0}, 32'd0);
    chk("rst_err0", {31'd0, err0}, 32'd0);
    chk("rst_rty0", {31'd0, rty0}, 32'd0);
    chk("rst_dat0", dat0, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("idle_ack1", {31'd0, ack1}, 32'd0);
    chk("idle_dat1", dat1, 32'd0);

    run_burst(0, 1'b1, 32'h0, CTI_INC, BTE_LINEAR, MEMW, 4'hF, $urandom, -1, 0, -1);

    wr1(0, 32'h10, 4'hF, 32'h0001_0203);
    rd1(0, 32'h10);

    for (int k = 0; k < 8; k++) wr1(0, 32'h1000 + 32'(4 * k), 4'hF, $urandom);
    run_burst(0, 1'b0, 32'h1000, CTI_INC, BTE_LINEAR, 8, 4'hF, 0, -1, 0, -1);
    run_burst(0, 1'b0, 32'h1008, CTI_INC, BTE_WRAP4, 4, 4'hF, 0, -1, 0, -1);
    run_burst(0, 1'b0, 32'h101C, CTI_INC, BTE_WRAP8, 8, 4'hF, 0, -1, 0, -1);
    run_burst(0, 1'b0, 32'h1034, CTI_INC, BTE_WRAP16, 16, 4'hF, 0, -1, 0, -1);

    wr1(1, 32'h2004, 4'hF, 32'hFFFF_FFFF);
    wr1(1, 32'h2004, 4'b0010, 32'h0102_0304);
    rd1(1, 32'h2004);
    run_burst(1, 1'b0, 32'h2004, CTI_INC, BTE_LINEAR, 1, 4'hF, 0, -1, 0, -1);

    run_burst(0, 1'b0, TOP - 32'd8, CTI_INC, BTE_LINEAR, 4, 4'hF, 0, -1, 0, -1);
    wr1(0, 32'h0, 4'hF, 32'hA5A5_5A5A);
    wr1(0, 32'h8000_0000, 4'hF, 32'h1234_5678);
    rd1(0, 32'h8000_0000);
    rd1(0, 32'h0);

    run_burst(0, 1'b1, 32'h3000, CTI_INC, BTE_LINEAR, 8, 4'hF, $urandom, 3, 2, -1);
    run_burst(0, 1'b0, 32'h3000, CTI_INC, BTE_LINEAR, 8, 4'hF, 0, 4, 2, -1);
    run_burst(0, 1'b1, 32'h3100, CTI_CONST, BTE_LINEAR, 3, 4'hF, $urandom, -1, 0, -1);
    rd1(0, 32'h3100);
    run_burst(0, 1'b0, 32'h3100, CTI_CONST, BTE_LINEAR, 4, 4'hF, 0, 2, 1, -1);

    run_burst(0, 1'b0, 32'h3000, CTI_INC, BTE_LINEAR, 8, 4'hF, 0, -1, 0, 3);
    rd1(0, 32'h3004);

    for (int k = 0; k < 40; k++) begin
      int          n, r;
      logic [2:0]  m;
      logic [31:0] a;
      r = $urandom_range(0, 2);
      m = (r == 0) ? CTI_CLASSIC : ((r == 1) ? CTI_INC : CTI_CONST);
      n = (r == 0) ? 1 : $urandom_range(2, 8);
      a = 32'($urandom_range(0, MEMW - 1)) << 2;
      run_burst(0, 1'($urandom_range(0, 1)), a, m, 2'($urandom_range(0, 3)), n,
                4'($urandom_range(0, 15)), $urandom, $urandom_range(1, 8), $urandom_range(1, 3), -1);
    end

    repeat (2) @(posedge clk);
    chk("pending_exp", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
